// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a valid/ready output stage
// backed by a one-entry skid register, so downstream stalls never lose or repeat a result.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_no_imm,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  localparam logic IS_RV64 = (XLEN == 32'sd64);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              in_ready_r;
  logic              out_valid_r;

  logic [XLEN-1:0]   m_imm_r;
  logic [2:0]        m_fmt_r;
  logic              m_no_imm_r;
  logic [TAG_W-1:0]  m_tag_r;
  logic [XLEN-1:0]   k_imm_r;
  logic [2:0]        k_fmt_r;
  logic              k_no_imm_r;
  logic [TAG_W-1:0]  k_tag_r;

  logic [6:0]        opc_s;
  logic [2:0]        funct3_s;
  logic              shift_op_s;
  logic [63:0]       imm_wide_s;
  logic [XLEN-1:0]   dec_imm_s;
  logic [2:0]        dec_fmt_s;
  logic              dec_no_imm_s;

  logic              accept_s;
  logic              ld_m_dec_s;
  logic              ld_m_skid_s;
  logic              ld_k_s;

  // Decoded values are built at 64 bits and truncated, which keeps RV32 and RV64 on one path.
  function automatic logic [63:0] sext12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction

  // Combinational decode of the incoming word into immediate, format and no-immediate flag.
  always_comb begin
    opc_s      = in_instr[6:0];
    funct3_s   = in_instr[14:12];
    shift_op_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);
    imm_wide_s = 64'd0;
    dec_fmt_s  = FMT_NONE;
    case (opc_s)
      7'b0010011: begin
        if (shift_op_s) begin
          dec_fmt_s = FMT_SHAMT;
          if (IS_RV64) begin
            imm_wide_s = {58'd0, in_instr[25:20]};
          end else begin
            imm_wide_s = {59'd0, in_instr[24:20]};
          end
        end else begin
          dec_fmt_s  = FMT_I;
          imm_wide_s = sext12(in_instr[31:20]);
        end
      end
      7'b0011011: begin
        // Word-sized ops only exist on RV64; on RV32 this opcode is treated as immediate-free.
        if (IS_RV64) begin
          if (shift_op_s) begin
            dec_fmt_s  = FMT_SHAMT;
            imm_wide_s = {59'd0, in_instr[24:20]};
          end else begin
            dec_fmt_s  = FMT_I;
            imm_wide_s = sext12(in_instr[31:20]);
          end
        end else begin
          dec_fmt_s  = FMT_NONE;
          imm_wide_s = 64'd0;
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt_s  = FMT_I;
        imm_wide_s = sext12(in_instr[31:20]);
      end
      7'b0100011: begin
        dec_fmt_s  = FMT_S;
        imm_wide_s = sext12({in_instr[31:25], in_instr[11:7]});
      end
      7'b1100011: begin
        dec_fmt_s  = FMT_B;
        imm_wide_s = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt_s  = FMT_U;
        imm_wide_s = {{32{in_instr[31]}}, in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt_s  = FMT_J;
        imm_wide_s = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      end
      default: begin
        dec_fmt_s  = FMT_NONE;
        imm_wide_s = 64'd0;
      end
    endcase
    dec_no_imm_s = (dec_fmt_s == FMT_NONE);
    dec_imm_s    = imm_wide_s[XLEN-1:0];
  end

  assign accept_s = in_valid & in_ready_r;

  // Next-state and register-load selection for the main/skid output stage.
  always_comb begin
    state_nx_s  = state_r;
    ld_m_dec_s  = 1'b0;
    ld_m_skid_s = 1'b0;
    ld_k_s      = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nx_s = ST_ONE;
          ld_m_dec_s = 1'b1;
        end else begin
          state_nx_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && out_ready) begin
          state_nx_s = ST_ONE;
          ld_m_dec_s = 1'b1;
        end else if (accept_s) begin
          state_nx_s = ST_FULL;
          ld_k_s     = 1'b1;
        end else if (out_ready) begin
          state_nx_s = ST_EMPTY;
        end else begin
          state_nx_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          state_nx_s  = ST_ONE;
          ld_m_skid_s = 1'b1;
        end else begin
          state_nx_s = ST_FULL;
        end
      end
      default: begin
        state_nx_s = ST_EMPTY;
      end
    endcase
  end

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s != ST_FULL);
      out_valid_r <= (state_nx_s != ST_EMPTY);
    end
  end

  // Main (M) and skid (K) data registers; a flush zeroes them so squashed data never shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_imm_r    <= '0;
      m_fmt_r    <= FMT_NONE;
      m_no_imm_r <= 1'b0;
      m_tag_r    <= '0;
      k_imm_r    <= '0;
      k_fmt_r    <= FMT_NONE;
      k_no_imm_r <= 1'b0;
      k_tag_r    <= '0;
    end else if (flush) begin
      m_imm_r    <= '0;
      m_fmt_r    <= FMT_NONE;
      m_no_imm_r <= 1'b0;
      m_tag_r    <= '0;
      k_imm_r    <= '0;
      k_fmt_r    <= FMT_NONE;
      k_no_imm_r <= 1'b0;
      k_tag_r    <= '0;
    end else begin
      if (ld_m_dec_s) begin
        m_imm_r    <= dec_imm_s;
        m_fmt_r    <= dec_fmt_s;
        m_no_imm_r <= dec_no_imm_s;
        m_tag_r    <= in_tag;
      end else if (ld_m_skid_s) begin
        m_imm_r    <= k_imm_r;
        m_fmt_r    <= k_fmt_r;
        m_no_imm_r <= k_no_imm_r;
        m_tag_r    <= k_tag_r;
      end
      if (ld_k_s) begin
        k_imm_r    <= dec_imm_s;
        k_fmt_r    <= dec_fmt_s;
        k_no_imm_r <= dec_no_imm_s;
        k_tag_r    <= in_tag;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_imm    = m_imm_r;
  assign out_fmt    = m_fmt_r;
  assign out_no_imm = m_no_imm_r;
  assign out_tag    = m_tag_r;

endmodule
